// File: rtl/alu_iter.sv
// alu_iter: single-issue ALU with an optional iterative shift-add multiplier.
//
// One request is accepted in IDLE (in_valid & in_ready). Single-cycle ops land
// in DONE on the accepting edge; MUL spends WIDTH cycles in the MUL state first.
// The result and flags are held in DONE until out_ready is seen.
//
// Build option: define ALU_ITER_MUL_EN to compile in the multiplier (op 8).
// Without it, op 8 is treated as an illegal opcode.
//
// Ports:
//   clock                  single clock, rising edge
//   reset                  synchronous, active-high
//   in_valid / in_ready    request handshake (in_ready only in IDLE)
//   op[3:0]                opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 EPAR, 5 XOR,
//                          6 SHL, 7 SHR, 8 MUL, others illegal
//   input_a / input_b      operands, WIDTH bits
//   out                    result, WIDTH bits
//   out_valid / out_ready  result handshake
//   flag_zero, flag_carry, flag_ovf, flag_illegal  status for the held result
module alu_iter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] input_a,
    input  logic [WIDTH-1:0] input_b,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             flag_zero,
    output logic             flag_carry,
    output logic             flag_ovf,
    output logic             flag_illegal
);

    localparam int unsigned ShW = $clog2(WIDTH);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StDone = 2'd2;
`ifdef ALU_ITER_MUL_EN
    localparam logic [1:0] StMul  = 2'd1;
    localparam logic [3:0] OpMul  = 4'd8;
`endif

    localparam logic [3:0] OpAdd  = 4'd0;
    localparam logic [3:0] OpSub  = 4'd1;
    localparam logic [3:0] OpAnd  = 4'd2;
    localparam logic [3:0] OpOr   = 4'd3;
    localparam logic [3:0] OpEpar = 4'd4;
    localparam logic [3:0] OpXor  = 4'd5;
    localparam logic [3:0] OpShl  = 4'd6;
    localparam logic [3:0] OpShr  = 4'd7;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             zero_q, zero_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic             ill_q, ill_d;

    // Single-cycle datapath, evaluated on the raw inputs at accept time.
    logic [WIDTH-1:0] alu_res;
    logic             alu_c, alu_v, alu_ill;
    logic [WIDTH:0]   sum, diff;
    logic [ShW-1:0]   shamt;

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_ill = 1'b0;
        sum     = {1'b0, input_a} + {1'b0, input_b};
        // Top bit of the widened difference is the unsigned borrow (a < b).
        diff    = {1'b0, input_a} - {1'b0, input_b};
        shamt   = input_b[ShW-1:0];
        case (op)
            OpAdd: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (input_a[WIDTH-1] == input_b[WIDTH-1]) &&
                          (sum[WIDTH-1] != input_a[WIDTH-1]);
            end
            OpSub: begin
                alu_res = diff[WIDTH-1:0];
                alu_c   = diff[WIDTH];
                alu_v   = (input_a[WIDTH-1] != input_b[WIDTH-1]) &&
                          (diff[WIDTH-1] != input_a[WIDTH-1]);
            end
            OpAnd:  alu_res = input_a & input_b;
            OpOr:   alu_res = input_a | input_b;
            OpEpar: alu_res = {{(WIDTH-1){1'b0}}, ~^input_a};
            OpXor:  alu_res = input_a ^ input_b;
            OpShl:  alu_res = input_a << shamt;
            OpShr:  alu_res = input_a >> shamt;
            default: alu_ill = 1'b1;  // MUL is diverted before this result is used
        endcase
    end

`ifdef ALU_ITER_MUL_EN
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [ShW-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0] prod_nxt;

    assign prod_nxt = prod_q + (mplier_q[0] ? mcand_q : '0);
`endif

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        zero_d  = zero_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        ill_d   = ill_q;
`ifdef ALU_ITER_MUL_EN
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;
`endif
        case (state_q)
            StIdle: begin
                if (in_valid) begin
`ifdef ALU_ITER_MUL_EN
                    if (op == OpMul) begin
                        state_d  = StMul;
                        mcand_d  = {{WIDTH{1'b0}}, input_a};
                        mplier_d = input_b;
                        prod_d   = '0;
                        cnt_d    = '0;
                    end else
`endif
                    begin
                        state_d = StDone;
                        out_d   = alu_res;
                        zero_d  = (alu_res == '0) && !alu_ill;
                        carry_d = alu_c;
                        ovf_d   = alu_v;
                        ill_d   = alu_ill;
                    end
                end
            end
`ifdef ALU_ITER_MUL_EN
            StMul: begin
                prod_d   = prod_nxt;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == ShW'(WIDTH - 1)) begin
                    state_d = StDone;
                    out_d   = prod_nxt[WIDTH-1:0];
                    zero_d  = (prod_nxt[WIDTH-1:0] == '0);
                    carry_d = |prod_nxt[2*WIDTH-1:WIDTH];
                    ovf_d   = 1'b0;
                    ill_d   = 1'b0;
                end
            end
`endif
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            out_q   <= '0;
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            zero_q  <= zero_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            ill_q   <= ill_d;
        end
    end

`ifdef ALU_ITER_MUL_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
        end
    end
`endif

    assign in_ready     = (state_q == StIdle);
    assign out_valid    = (state_q == StDone);
    assign out          = out_q;
    assign flag_zero    = zero_q;
    assign flag_carry   = carry_q;
    assign flag_ovf     = ovf_q;
    assign flag_illegal = ill_q;

endmodule

// File: doc/alu_iter.md
ALU_ITER -- requirements
Module: alu_iter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the operand/result width; legal values are powers of two, 8..64.
REQ-002 The block SHALL have port clock, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port in_valid, input, 1, meaning the operands and op are valid.
REQ-005 The block SHALL have port in_ready, output, 1, meaning the block accepts a request this cycle.
REQ-006 The block SHALL have port op, input, 4, the opcode.
REQ-007 The block SHALL have ports input_a and input_b, input, WIDTH, the operands.
REQ-008 The block SHALL have port out, output, WIDTH, the result.
REQ-009 The block SHALL have port out_valid, output, 1, meaning the result is valid.
REQ-010 The block SHALL have port out_ready, input, 1, meaning the consumer takes the result.
REQ-011 The block SHALL have ports flag_zero, flag_carry, flag_ovf and flag_illegal, output, 1 each, status for the current result.

Function
REQ-012 The block SHALL have states IDLE, MUL and DONE; in_ready SHALL equal 1 only in IDLE.
REQ-013 Accept occurs when in_valid & in_ready in IDLE; op, input_a and input_b SHALL be captured on that edge.
REQ-014 Opcodes SHALL be 0 ADD, 1 SUB (a-b), 2 AND, 3 OR, 4 EPAR, 5 XOR, 6 SHL, 7 SHR (logical), 8 MUL, 9-15 illegal.
REQ-015 For EPAR, out SHALL be {WIDTH-1 zeros, 1 if input_a has an even count of ones else 0}.
REQ-016 For SHL and SHR, the shift amount SHALL be input_b[$clog2(WIDTH)-1:0]; upper bits of input_b are ignored.
REQ-017 Non-MUL ops SHALL go IDLE->DONE, with out_valid=1 on the cycle after accept (latency 1).
REQ-018 MUL SHALL go IDLE->MUL, perform WIDTH shift-add iterations (one per cycle) in MUL, then enter DONE, with out_valid=1 exactly WIDTH+1 cycles after accept.
REQ-019 For MUL, out SHALL be the low WIDTH bits of the unsigned 2*WIDTH product.
REQ-020 In DONE, out, out_valid and the flags SHALL hold stable until out_ready=1; on that edge the state SHALL become IDLE and out_valid 0.
REQ-021 A new request SHALL NOT be accepted in the same cycle a result is consumed; the earliest accept is the following cycle.
REQ-022 flag_zero SHALL be (out==0) for every op.
REQ-023 flag_carry SHALL be the ADD carry-out, the SUB borrow (a<b unsigned), MUL upper product half !=0, and 0 otherwise.
REQ-024 flag_ovf SHALL be signed two's-complement overflow for ADD and SUB, and 0 otherwise.
REQ-025 An illegal op SHALL give out=0, flag_illegal=1, other flags 0, latency 1; flag_illegal SHALL be 0 for legal ops.
REQ-026 Inputs SHALL be ignored outside IDLE; in_valid pulses while busy are dropped without side effect.

Reset
REQ-027 With reset=1 at an edge, the state SHALL be IDLE, out=0, out_valid=0, all flags 0, and in_ready=1 from the next cycle.
REQ-028 Reset SHALL override any concurrent accept or consume, and SHALL abort an in-progress MUL or a pending DONE result with no output produced.

Configuration
REQ-029 With macro ALU_ITER_MUL_EN defined, the iterative multiplier and MUL state SHALL be compiled in, with behaviour per REQ-018/019.
REQ-030 Without ALU_ITER_MUL_EN, op 8 SHALL behave as illegal (REQ-025), the MUL state and its datapath SHALL be absent, and all other ops SHALL be unchanged.

Verification (WIDTH=16)
REQ-031 The bench SHALL cover: ADD 0xFFFF+0x0001 -> out=0x0000, zero=1, carry=1, ovf=0, out_valid 1 cycle after accept.
REQ-032 The bench SHALL cover: SUB 0x8000-0x0001 -> out=0x7FFF, ovf=1, carry=0; SUB 1-1 -> out=0, zero=1; EPAR a=0x0003 -> out=1; EPAR a=0x0002 -> out=0.
REQ-033 The bench SHALL cover, with ALU_ITER_MUL_EN: MUL 300*300 -> out=0x5F90, carry=1, out_valid exactly 17 cycles after accept, in_ready=0 throughout.
REQ-034 The bench SHALL cover: OR 0x00F0|0x000F with out_ready=0 for 5 cycles -> out=0x00FF stable, in_ready=0, and new in_valid ignored; out_ready=1 -> IDLE next cycle.
REQ-035 The bench SHALL cover: reset asserted 5 cycles into a MUL -> next cycle out_valid=0, in_ready=1, out=0; op=12 -> out=0, flag_illegal=1.
REQ-036 The bench SHALL cover, without ALU_ITER_MUL_EN: op=8 -> flag_illegal=1, latency 1.
